// File: rtl/tl_ul_req_rsp_buffer_pkg.sv
// TL-UL types and payload helpers shared by the request/response buffer.
// Optional status outputs are enabled by TL_UL_REQ_RSP_BUFFER_STATUS_EN.
package tl_ul_req_rsp_buffer_pkg;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    logic        d_ready;
  } tl_m2s_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
    logic        a_ready;
  } tl_s2m_t;

  typedef struct packed {
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
  } tl_a_payload_t;

  typedef struct packed {
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    logic        d_error;
  } tl_d_payload_t;

  function automatic tl_a_payload_t a_payload(tl_m2s_t m);
    tl_a_payload_t p;
    p.a_opcode  = m.a_opcode;
    p.a_param   = m.a_param;
    p.a_size    = m.a_size;
    p.a_source  = m.a_source;
    p.a_address = m.a_address;
    p.a_mask    = m.a_mask;
    p.a_data    = m.a_data;
    return p;
  endfunction

  function automatic tl_m2s_t a_to_m2s(tl_a_payload_t p, logic vld,
                                       logic rdy);
    tl_m2s_t m;
    m.a_valid   = vld;
    m.a_opcode  = p.a_opcode;
    m.a_param   = p.a_param;
    m.a_size    = p.a_size;
    m.a_source  = p.a_source;
    m.a_address = p.a_address;
    m.a_mask    = p.a_mask;
    m.a_data    = p.a_data;
    m.d_ready   = rdy;
    return m;
  endfunction

  function automatic tl_d_payload_t d_payload(tl_s2m_t s);
    tl_d_payload_t p;
    p.d_opcode = s.d_opcode;
    p.d_param  = s.d_param;
    p.d_size   = s.d_size;
    p.d_source = s.d_source;
    p.d_sink   = s.d_sink;
    p.d_data   = s.d_data;
    p.d_error  = s.d_error;
    return p;
  endfunction

  function automatic tl_s2m_t d_to_s2m(tl_d_payload_t p, logic vld,
                                       logic rdy);
    tl_s2m_t s;
    s.d_valid  = vld;
    s.d_opcode = p.d_opcode;
    s.d_param  = p.d_param;
    s.d_size   = p.d_size;
    s.d_source = p.d_source;
    s.d_sink   = p.d_sink;
    s.d_data   = p.d_data;
    s.d_error  = p.d_error;
    s.a_ready  = rdy;
    return s;
  endfunction

endpackage

// File: rtl/tl_ul_req_rsp_buffer_sync_fifo.sv
// Registered first-word fall-through FIFO, any depth >= 1.
// Used by tl_ul_req_rsp_buffer (TL_UL_REQ_RSP_BUFFER_STATUS_EN exposes count).
module tl_ul_sync_fifo #(
  parameter int Width = 8,
  parameter int Depth = 2,
  localparam int CW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wvalid_i,
  output logic             wready_o,
  input  logic [Width-1:0] wdata_i,
  output logic             rvalid_o,
  input  logic             rready_i,
  output logic [Width-1:0] rdata_o,
  output logic [CW-1:0]    count_o
);

  localparam int PW = (Depth > 1) ? $clog2(Depth) : 1;

  if (Depth < 1) begin : g_depth_chk
    $fatal(1, "tl_ul_sync_fifo: Depth must be >= 1");
  end

  logic [Width-1:0] mem [Depth];
  logic [PW-1:0]    wptr, rptr;
  logic [CW-1:0]    count;
  logic             push, pop;

  function automatic logic [PW-1:0] nxt(logic [PW-1:0] p);
    return (p == PW'(Depth - 1)) ? '0 : p + PW'(1);
  endfunction

  assign wready_o = !rst_i && (count != CW'(Depth));
  assign rvalid_o = !rst_i && (count != '0);
  assign push     = wvalid_i && wready_o;
  assign pop      = rvalid_o && rready_i;
  assign rdata_o  = mem[rptr];
  assign count_o  = count;

  // storage, pointers and occupancy
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= wdata_i;
        wptr      <= nxt(wptr);
      end
      if (pop) rptr <= nxt(rptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/tl_ul_req_rsp_buffer.sv
// Registered TL-UL A/D buffer with an outstanding-request cap.
// Define TL_UL_REQ_RSP_BUFFER_STATUS_EN for count/outstanding outputs.
module tl_ul_req_rsp_buffer
  import tl_ul_req_rsp_buffer_pkg::*;
#(
  parameter int ReqDepth       = 2,
  parameter int RspDepth       = 2,
  parameter int MaxOutstanding = 4,
  localparam int RqW = $clog2(ReqDepth + 1),
  localparam int RsW = $clog2(RspDepth + 1),
  localparam int OW  = $clog2(MaxOutstanding + 1)
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  tl_m2s_t        tl_h_i,
  output tl_s2m_t        tl_h_o,
  output tl_m2s_t        tl_d_o,
`ifdef TL_UL_REQ_RSP_BUFFER_STATUS_EN
  input  tl_s2m_t        tl_d_i,
  output logic [RqW-1:0] req_count_o,
  output logic [RsW-1:0] rsp_count_o,
  output logic [OW-1:0]  outstanding_o
`else
  input  tl_s2m_t        tl_d_i
`endif
);

  if (MaxOutstanding < 1) begin : g_max_chk
    $fatal(1, "tl_ul_req_rsp_buffer: MaxOutstanding must be >= 1");
  end

  tl_a_payload_t  req_rdata;
  tl_d_payload_t  rsp_rdata;
  logic           req_wready, req_rvalid;
  logic           rsp_wready, rsp_rvalid;
  logic [RqW-1:0] req_count;
  logic [RsW-1:0] rsp_count;
  logic [OW-1:0]  outst;
  logic           a_ready, a_hs, d_hs;

  assign a_ready = req_wready && (outst < OW'(MaxOutstanding));
  assign a_hs    = tl_h_i.a_valid && a_ready;
  assign d_hs    = rsp_rvalid && tl_h_i.d_ready;

  tl_ul_sync_fifo #(
    .Width($bits(tl_a_payload_t)),
    .Depth(ReqDepth)
  ) u_req_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wvalid_i (a_hs),
    .wready_o (req_wready),
    .wdata_i  (a_payload(tl_h_i)),
    .rvalid_o (req_rvalid),
    .rready_i (tl_d_i.a_ready),
    .rdata_o  (req_rdata),
    .count_o  (req_count)
  );

  tl_ul_sync_fifo #(
    .Width($bits(tl_d_payload_t)),
    .Depth(RspDepth)
  ) u_rsp_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .wvalid_i (tl_d_i.d_valid),
    .wready_o (rsp_wready),
    .wdata_i  (d_payload(tl_d_i)),
    .rvalid_o (rsp_rvalid),
    .rready_i (tl_h_i.d_ready),
    .rdata_o  (rsp_rdata),
    .count_o  (rsp_count)
  );

  assign tl_d_o = a_to_m2s(req_rdata, req_rvalid, rsp_wready);
  assign tl_h_o = d_to_s2m(rsp_rdata, rsp_rvalid, a_ready);

  // requests accepted from the host but not yet answered
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outst <= '0;
    end else begin
      unique case (1'b1)
        a_hs && !d_hs: outst <= outst + OW'(1);
        d_hs && !a_hs: outst <= outst - OW'(1);
        default:       outst <= outst;
      endcase
    end
  end

`ifdef TL_UL_REQ_RSP_BUFFER_STATUS_EN
  assign req_count_o   = req_count;
  assign rsp_count_o   = rsp_count;
  assign outstanding_o = outst;
`endif

  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(d_hs && !a_hs && outst == '0));

  a_req_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    req_count <= RqW'(ReqDepth));

  a_rsp_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    rsp_count <= RsW'(RspDepth));

endmodule

// File: tb/tb_tl_ul_req_rsp_buffer.sv
// Scoreboard bench for tl_ul_req_rsp_buffer (default build).
// Bench plays both the host and the bridge.
module tb_tl_ul_req_rsp_buffer;
  import tl_ul_req_rsp_buffer_pkg::*;

  logic    clk = 1'b0;
  logic    rst_i;
  tl_m2s_t tl_h_i, tl_d_o;
  tl_s2m_t tl_h_o, tl_d_i;

  int n_tests = 0;
  int n_fail  = 0;
  int acc;

  tl_a_payload_t exp_a[$];
  tl_d_payload_t exp_d[$];
  tl_a_payload_t ea;
  tl_d_payload_t ed;

  always #5 clk = ~clk;

  tl_ul_req_rsp_buffer #(
    .ReqDepth(2),
    .RspDepth(2),
    .MaxOutstanding(4)
  ) dut (
    .clk_i  (clk),
    .rst_i  (rst_i),
    .tl_h_i (tl_h_i),
    .tl_h_o (tl_h_o),
    .tl_d_o (tl_d_o),
    .tl_d_i (tl_d_i)
  );

  // scoreboard: inputs are stable at negedge, so handshakes seen here
  // are the ones taken at the next posedge; pops go before pushes
  always @(negedge clk) begin
    if (rst_i === 1'b0) begin
      if (tl_d_o.a_valid && tl_d_i.a_ready) begin
        n_tests++;
        if (exp_a.size() == 0) begin
          n_fail++;
          $display("FAIL a_beat: got %h, required none", a_payload(tl_d_o));
        end else begin
          ea = exp_a.pop_front();
          if (a_payload(tl_d_o) !== ea) begin
            n_fail++;
            $display("FAIL a_beat: got %h, required %h",
                     a_payload(tl_d_o), ea);
          end
        end
      end
      if (tl_h_o.d_valid && tl_h_i.d_ready) begin
        n_tests++;
        if (exp_d.size() == 0) begin
          n_fail++;
          $display("FAIL d_beat: got %h, required none", d_payload(tl_h_o));
        end else begin
          ed = exp_d.pop_front();
          if (d_payload(tl_h_o) !== ed) begin
            n_fail++;
            $display("FAIL d_beat: got %h, required %h",
                     d_payload(tl_h_o), ed);
          end
        end
      end
      if (tl_h_i.a_valid && tl_h_o.a_ready)
        exp_a.push_back(a_payload(tl_h_i));
      if (tl_d_i.d_valid && tl_d_o.d_ready)
        exp_d.push_back(d_payload(tl_d_i));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic host_a(tl_a_op_e op, int src, logic [31:0] addr,
                        logic [31:0] data);
    tl_h_i.a_valid   = 1'b1;
    tl_h_i.a_opcode  = op;
    tl_h_i.a_param   = 3'd0;
    tl_h_i.a_size    = 2'd2;
    tl_h_i.a_source  = 8'(src);
    tl_h_i.a_address = addr;
    tl_h_i.a_mask    = 4'hf;
    tl_h_i.a_data    = data;
  endtask

  // bridge returns one D beat, waiting a bounded time for d_ready
  task automatic bridge_d(int src, logic [31:0] data, logic err);
    bit done = 0;
    tl_d_i.d_valid  = 1'b1;
    tl_d_i.d_opcode = AccessAckData;
    tl_d_i.d_param  = 3'd0;
    tl_d_i.d_size   = 2'd2;
    tl_d_i.d_source = 8'(src);
    tl_d_i.d_sink   = 1'b0;
    tl_d_i.d_data   = data;
    tl_d_i.d_error  = err;
    for (int k = 0; k < 20 && !done; k++) begin
      if (tl_d_o.d_ready) done = 1;
      tick();
    end
    tl_d_i.d_valid = 1'b0;
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL bridge_d_timeout: got d_ready 0, required 1");
    end
  endtask

  // host streams Gets for n cycles with a fresh source on each accept
  task automatic stream_gets(int n, int base, output int got);
    got = 0;
    for (int c = 0; c < n; c++) begin
      host_a(Get, base + got, 32'h2000 + 32'(got * 4), 32'h0);
      #1;
      if (tl_h_o.a_ready) got++;
      tick();
    end
    tl_h_i.a_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    tl_h_i = '0;
    tl_d_i = '0;
    tl_h_i.a_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (tl_h_o.a_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_a_ready[%0d]: got %b required 0", i,
                 tl_h_o.a_ready);
      end
      n_tests++;
      if (tl_h_o.d_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_d_valid[%0d]: got %b required 0", i,
                 tl_h_o.d_valid);
      end
    end
    rst_i = 1'b0;
    tl_h_i.a_valid = 1'b0;
    #1;
    n_tests++;
    if (tl_h_o.a_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_rst_a_ready: got %b required 1", tl_h_o.a_ready);
    end
    n_tests++;
    if (tl_d_o.a_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_rst_a_valid: got %b required 0", tl_d_o.a_valid);
    end
    tick();
  endtask

  task automatic test_single_get;
    tl_d_i.a_ready = 1'b1;
    tl_h_i.d_ready = 1'b1;
    host_a(Get, 3, 32'h1000, 32'h0);
    #1;
    n_tests++;
    if (tl_d_o.a_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL get_no_bypass: got %b required 0", tl_d_o.a_valid);
    end
    tick();
    tl_h_i.a_valid = 1'b0;
    #1;
    n_tests++;
    if (tl_d_o.a_valid !== 1'b1 || tl_d_o.a_address !== 32'h1000 ||
        tl_d_o.a_source !== 8'd3) begin
      n_fail++;
      $display("FAIL get_fwd: got v%b a%h s%0d required v1 a1000 s3",
               tl_d_o.a_valid, tl_d_o.a_address, tl_d_o.a_source);
    end
    tick();
    tl_d_i.d_valid  = 1'b1;
    tl_d_i.d_opcode = AccessAckData;
    tl_d_i.d_size   = 2'd2;
    tl_d_i.d_source = 8'd3;
    tl_d_i.d_data   = 32'hDEADBEEF;
    tl_d_i.d_error  = 1'b0;
    #1;
    n_tests++;
    if (tl_h_o.d_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rsp_no_bypass: got %b required 0", tl_h_o.d_valid);
    end
    tick();
    tl_d_i.d_valid = 1'b0;
    #1;
    n_tests++;
    if (tl_h_o.d_valid !== 1'b1 || tl_h_o.d_data !== 32'hDEADBEEF ||
        tl_h_o.d_source !== 8'd3) begin
      n_fail++;
      $display("FAIL rsp_fwd: got v%b d%h s%0d required v1 dDEADBEEF s3",
               tl_h_o.d_valid, tl_h_o.d_data, tl_h_o.d_source);
    end
    tick();
    n_tests++;
    if (tl_h_o.d_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rsp_pop: got %b required 0", tl_h_o.d_valid);
    end
  endtask

  task automatic test_backpressure;
    int idx = 0;
    tl_d_i.a_ready = 1'b0;
    tl_h_i.d_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      host_a(PutFullData, idx, 32'h3000 + 32'(idx * 4), 32'hA0 + 32'(idx));
      #1;
      if (c >= 2) begin
        n_tests++;
        if (tl_h_o.a_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_a_ready[%0d]: got %b required 0", c,
                   tl_h_o.a_ready);
        end
      end
      if (tl_h_o.a_ready) idx++;
      tick();
    end
    tl_h_i.a_valid = 1'b0;
    n_tests++;
    if (idx !== 2) begin
      n_fail++;
      $display("FAIL bp_accepted: got %0d required 2", idx);
    end
    tl_d_i.a_ready = 1'b1;
    repeat (3) tick();
    n_tests++;
    if (tl_d_o.a_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drained: got %b required 0", tl_d_o.a_valid);
    end
    bridge_d(0, 32'h0, 1'b0);
    bridge_d(1, 32'h0, 1'b0);
    repeat (2) tick();
  endtask

  task automatic test_outstanding_cap;
    tl_d_i.a_ready = 1'b1;
    tl_h_i.d_ready = 1'b1;
    stream_gets(7, 8'h10, acc);
    n_tests++;
    if (acc !== 4) begin
      n_fail++;
      $display("FAIL cap_accepted: got %0d required 4", acc);
    end
    host_a(Get, 8'h14, 32'h2010, 32'h0);
    bridge_d(8'h10, 32'h10, 1'b0);
    n_tests++;
    if (tl_h_o.a_ready !== 1'b0 || tl_h_o.d_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL cap_hold: got rdy%b dv%b required rdy0 dv1",
               tl_h_o.a_ready, tl_h_o.d_valid);
    end
    tick();
    n_tests++;
    if (tl_h_o.a_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL cap_release: got %b required 1", tl_h_o.a_ready);
    end
    tick();
    tl_h_i.a_valid = 1'b0;
    n_tests++;
    if (tl_h_o.a_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL cap_refill: got %b required 0", tl_h_o.a_ready);
    end
    for (int i = 0; i < 4; i++) bridge_d(8'h11 + i, 32'h11 + 32'(i), 1'b0);
    repeat (2) tick();
  endtask

  task automatic test_back_to_back;
    tl_d_i.a_ready = 1'b1;
    tl_h_i.d_ready = 1'b1;
    stream_gets(2, 8'h20, acc);
    n_tests++;
    if (acc !== 2) begin
      n_fail++;
      $display("FAIL b2b_first: got %0d required 2", acc);
    end
    bridge_d(8'h20, 32'h20, 1'b0);
    host_a(Get, 8'h22, 32'h2100, 32'h0);
    #1;
    n_tests++;
    if (tl_h_o.a_ready !== 1'b1 || tl_h_o.d_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_both: got rdy%b dv%b required rdy1 dv1",
               tl_h_o.a_ready, tl_h_o.d_valid);
    end
    tick();
    stream_gets(5, 8'h23, acc);
    n_tests++;
    if (acc !== 2) begin
      n_fail++;
      $display("FAIL b2b_count_kept: got %0d accepted required 2", acc);
    end
    for (int i = 0; i < 3; i++) bridge_d(8'h21 + i, 32'h21 + 32'(i), 1'b0);
    bridge_d(7, 32'h0BAD, 1'b1);
    n_tests++;
    if (tl_h_o.d_valid !== 1'b1 || tl_h_o.d_error !== 1'b1 ||
        tl_h_o.d_source !== 8'd7) begin
      n_fail++;
      $display("FAIL err_pass: got v%b e%b s%0d required v1 e1 s7",
               tl_h_o.d_valid, tl_h_o.d_error, tl_h_o.d_source);
    end
    repeat (2) tick();
  endtask

  task automatic test_mid_reset;
    tl_d_i.a_ready = 1'b0;
    tl_h_i.d_ready = 1'b0;
    stream_gets(2, 8'h30, acc);
    bridge_d(8'h30, 32'h30, 1'b0);
    n_tests++;
    if (tl_h_o.d_valid !== 1'b1 || tl_d_o.a_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mr_pre: got dv%b av%b required dv1 av1",
               tl_h_o.d_valid, tl_d_o.a_valid);
    end
    rst_i = 1'b1;
    exp_a.delete();
    exp_d.delete();
    tick();
    rst_i = 1'b0;
    #1;
    n_tests++;
    if (tl_h_o.d_valid !== 1'b0 || tl_d_o.a_valid !== 1'b0 ||
        tl_h_o.a_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mr_post: got dv%b av%b rdy%b required dv0 av0 rdy1",
               tl_h_o.d_valid, tl_d_o.a_valid, tl_h_o.a_ready);
    end
    tl_d_i.a_ready = 1'b1;
    tl_h_i.d_ready = 1'b1;
    stream_gets(6, 8'h40, acc);
    n_tests++;
    if (acc !== 4) begin
      n_fail++;
      $display("FAIL mr_counter: got %0d accepted required 4", acc);
    end
    repeat (3) tick();
    n_tests++;
    if (tl_h_o.d_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mr_stale_d: got %b required 0", tl_h_o.d_valid);
    end
    for (int i = 0; i < 4; i++) bridge_d(8'h40 + i, 32'h40 + 32'(i), 1'b0);
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_single_get();
    test_backpressure();
    test_outstanding_cap();
    test_back_to_back();
    test_mid_reset();
    n_tests++;
    if (exp_a.size() != 0 || exp_d.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: got a%0d d%0d required a0 d0",
               exp_a.size(), exp_d.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tl_ul_req_rsp_buffer.md
Name: tl_ul_req_rsp_buffer

Overview:
- Synchronous TL-UL buffering stage placed directly upstream of the TL-UL to AHB bridge: host-side TL-UL slave port in, device-side TL-UL master port out (to the bridge).
- Registers the A channel towards the bridge and the D channel back to the host, cutting combinational valid/ready paths.
- Enforces a cap on requests in flight so the bridge and AHB side never see more outstanding transactions than allowed.

Parameters:
- ReqDepth, 2, A-channel FIFO entries; must be >= 1, elaboration $fatal otherwise.
- RspDepth, 2, D-channel FIFO entries; must be >= 1, elaboration $fatal otherwise.
- MaxOutstanding, 4, maximum accepted A beats without a delivered D beat; must be >= 1.

Ports:
- clk_i  input  1  sole clock, all state on posedge.
- rst_i  input  1  synchronous active-high reset.
- tl_h_i  input  tl_m2s_t  host-side request and d_ready.
- tl_h_o  output  tl_s2m_t  host-side a_ready and response.
- tl_d_o  output  tl_m2s_t  device-side request and d_ready, to the bridge.
- tl_d_i  input  tl_s2m_t  device-side a_ready and response, from the bridge.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high.
- Reset values:
  - While rst_i = 1, tl_h_o.a_ready, tl_h_o.d_valid, tl_d_o.a_valid and tl_d_o.d_ready are forced to 0.
  - FIFOs reset to empty; outstanding counter resets to 0.
  - Payload fields are don't-care, but must be driven from the FIFO head, never X-propagated.
- A path:
  - Push on tl_h_i.a_valid & tl_h_o.a_ready, storing opcode, param, size, source, address, mask and data.
  - tl_h_o.a_ready = !req_full & (outstanding < MaxOutstanding).
  - tl_d_o.a_valid = !req_empty; payload is the FIFO head (first-word fall-through).
  - Pop on tl_d_o.a_valid & tl_d_i.a_ready.
- D path:
  - Push on tl_d_i.d_valid & tl_d_o.d_ready, with tl_d_o.d_ready = !rsp_full.
  - tl_h_o.d_valid = !rsp_empty; all d_* fields come from the head.
  - Pop on tl_h_o.d_valid & tl_h_i.d_ready.
- Latency: minimum 1 cycle per direction (push in cycle N, head valid in N+1). No same-cycle bypass when empty.
- Full FIFO: ready stays low even if a pop happens the same cycle. Ready is a pure function of registered state, so there is no ready-to-ready combinational path.
- Simultaneous push and pop on a non-empty FIFO: count unchanged, both pointers advance.
- Pointers wrap from Depth-1 to 0; non-power-of-2 depths are legal. Count width is $clog2(Depth+1).
- Outstanding counter, width $clog2(MaxOutstanding+1):
  - +1 on host A handshake, -1 on host D handshake, unchanged when both occur.
  - Never exceeds MaxOutstanding. Underflow (D with counter 0) is impossible by construction; assertion flags it.
- Ordering: strict FIFO, no reordering by source. Payload passes through unmodified; d_error from the bridge is forwarded as-is.
- Reset mid-operation: buffered beats are dropped and the counter is cleared. The bridge must be reset in the same cycle; the host must treat in-flight requests as lost.

Optional Feature:
- Macro TL_UL_REQ_RSP_BUFFER_STATUS_EN.
- Defined: adds three outputs:
  - req_count_o [$clog2(ReqDepth+1)]
  - rsp_count_o [$clog2(RspDepth+1)]
  - outstanding_o [$clog2(MaxOutstanding+1)]
  - All are registered values, 0 in reset.
- Undefined: ports absent, behaviour otherwise identical.

Decomposition:
- TileLinkUL_pkg gains two packed typedefs:
  - tl_a_payload_t: all a_* except a_valid.
  - tl_d_payload_t: all d_* except d_valid.
- TileLinkUL_pkg also gains pack/unpack functions to and from tl_m2s_t / tl_s2m_t.
- One sub-module, tl_ul_sync_fifo, instantiated twice:
  - Parameters: Width, Depth.
  - Ports: clk_i, rst_i, wvalid_i, wready_o, wdata_i, rvalid_o, rready_i, rdata_o, count_o.
- The outstanding counter stays in the top.

Test Plan:
- Reset release: hold rst_i 3 cycles with tl_h_i.a_valid = 1 -> a_ready = 0 and d_valid = 0 throughout. The cycle after release, a_ready = 1 and tl_d_o.a_valid = 0.
- Single Get:
  - Host sends address 0x1000, source 3; bridge a_ready held 1 -> tl_d_o.a_valid rises exactly 1 cycle later with identical fields.
  - Bridge returns AccessAckData, data 0xDEADBEEF -> tl_h_o.d_valid 1 cycle later with the same data and source 3.
- Backpressure: ReqDepth = 2, bridge a_ready = 0, host streams 5 Puts -> exactly 2 accepted, a_ready low from the cycle after the 2nd. After a_ready releases, order is preserved.
- Outstanding cap: MaxOutstanding = 4, bridge answers nothing -> 4 A beats accepted and the 5th stalls. One D delivered to the host -> a_ready high on the next cycle, 5th accepted.
- Simultaneous host A and D handshakes with counter at 2 -> counter stays 2. Error pass-through: bridge D with d_error = 1 and source 7 -> host sees d_error = 1 and source 7.
- Mid-operation reset with 2 requests and 1 response buffered -> after 1 reset cycle all valids 0, counter 0, no stale beat emitted afterward.
